ring_router_demux_multi: RTL

- Parametrised ring-router ingress demultiplexer. Steers wormhole packets arriving on the ring input to one of NUM_LOCAL local endpoints, onward along the ring, or (broadcast) to all of them at once.
- Sits between a ring segment and a cluster of debug/NoC endpoints that own a contiguous ID range.
- Adds three things over the single-endpoint demux: multi-endpoint decode, configurable widths, and a lossless eager-fork broadcast.

---
 rtl/ring_router_demux_multi.sv | 112 +++++++++++
 1 files changed

// File: rtl/ring_router_demux_multi.sv
// Ring-router ingress demultiplexer.
// Steers wormhole packets from the ring input to one of NUM_LOCAL local
// endpoints, onward along the ring, or (broadcast) to every target at once.
// The datapath is a zero-latency pass-through. Only the routing state (worm
// target set and per-target delivery flags) is registered.
module ring_router_demux_multi #(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ID_WIDTH   = 16,
  parameter int                  NUM_LOCAL  = 1,
  parameter bit                  BCAST_EN   = 1'b0,
  parameter logic [ID_WIDTH-1:0] BCAST_ID   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   base_id,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_local_data,
  output logic                  out_local_last,
  output logic [NUM_LOCAL-1:0]  out_local_valid,
  input  logic [NUM_LOCAL-1:0]  out_local_ready,
  output logic [DATA_WIDTH-1:0] out_ring_data,
  output logic                  out_ring_last,
  output logic                  out_ring_valid,
  input  logic                  out_ring_ready
);

  // Targets 0..NUM_LOCAL-1 are the local endpoints, target NUM_LOCAL is the ring.
  localparam int NT = NUM_LOCAL + 1;

  typedef enum logic {
    IDLE,
    WORM
  } state_t;

  state_t              state;
  logic [NT-1:0]       worm_sel;
  logic [NT-1:0]       done;
  logic [NT-1:0]       hdr_sel;
  logic [NT-1:0]       sel;
  logic [NT-1:0]       tgt_ready;
  logic [NT-1:0]       tgt_valid;
  logic [ID_WIDTH-1:0] dest;
  logic [ID_WIDTH:0]   off;
  logic                local_hit;
  logic                consume;

  // Offset is computed one bit wider than the IDs: the top bit is the borrow,
  // so dest < base_id never aliases onto a local slot, and a range that runs
  // past the top of the ID space simply truncates instead of wrapping to 0.
  assign dest      = in_data[ID_WIDTH-1:0];
  assign off       = {1'b0, dest} - {1'b0, base_id};
  assign local_hit = !off[ID_WIDTH] && (off < (ID_WIDTH+1)'(NUM_LOCAL));

  // Header decode: broadcast beats a local hit, anything else goes to the ring.
  always_comb begin
    // NOTE: default every output of a combinational block first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    hdr_sel = '0;
    if (BCAST_EN && dest == BCAST_ID) begin
      hdr_sel = '1;
    end else if (local_hit) begin
      for (int k = 0; k < NUM_LOCAL; k++) begin
        hdr_sel[k] = (off[ID_WIDTH-1:0] == ID_WIDTH'(k));
      end
    end else begin
      hdr_sel[NUM_LOCAL] = 1'b1;
    end
  end

  // Body flits follow the target set latched from their header.
  assign sel       = (state == WORM) ? worm_sel : hdr_sel;
  assign tgt_ready = {out_ring_ready, out_local_ready};

  // Eager fork: each selected target that has not yet taken this flit sees it
  // valid; the flit is consumed once every selected target has taken it or is
  // taking it now. Everything is held off while reset is asserted.
  assign tgt_valid = {NT{in_valid & rst}} & sel & ~done;
  assign in_ready  = rst & (&(~sel | done | tgt_ready));
  assign consume   = in_valid & in_ready;

  assign out_local_data  = in_data;
  assign out_local_last  = in_last;
  assign out_local_valid = tgt_valid[NUM_LOCAL-1:0];
  assign out_ring_data   = in_data;
  assign out_ring_last   = in_last;
  assign out_ring_valid  = tgt_valid[NUM_LOCAL];

  // Routing state: worm tracking plus per-target delivery flags for the current flit.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst) begin
      state    <= IDLE;
      worm_sel <= '0;
      done     <= '0;
    end else if (consume) begin
      done <= '0;
      if (in_last) begin
        state <= IDLE;
      end else begin
        state    <= WORM;
        worm_sel <= sel;
      end
    end else begin
      done <= done | (tgt_valid & tgt_ready);
    end
  end

endmodule
